// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, instruction field positions, default widths.
package mips_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_REG_CNT = 32;
  localparam int DEF_ADDR_W  = 5;

  localparam logic [5:0] R_FORM  = 6'h00;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  // Instructions whose rt field is a source operand rather than the destination.
  function automatic logic op_uses_rt(input logic [5:0] op);
    return (op == R_FORM) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic op_zero_ext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// IF->ID instruction handshake, write-back port, EX hazard info and ID->EX stage outputs.
interface id_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       Ins;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              ex_load;
  logic [ADDR_W-1:0] ex_dst;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] Rdata1;
  logic [DATA_W-1:0] Rdata2;
  logic [DATA_W-1:0] Ed32;
  logic [ADDR_W-1:0] dst;
  logic              is_rform;

  modport master (
    output in_valid, Ins, wb_en, wb_addr, wb_data, ex_load, ex_dst, out_ready,
    input  in_ready, out_valid, Rdata1, Rdata2, Ed32, dst, is_rform
  );

  modport slave (
    input  in_valid, Ins, wb_en, wb_addr, wb_data, ex_load, ex_dst, out_ready,
    output in_ready, out_valid, Rdata1, Rdata2, Ed32, dst, is_rform
  );
endinterface

// File: rtl/regfile_2r1w.sv
// Two-read one-write register file, r0 reads zero, out-of-range reads zero, sync reset.
// ID_WB_BYPASS_EN: a same-cycle write is forwarded to matching read ports (write-first).
module regfile_2r1w #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT = REG_CNT[ADDR_W:0];

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_hit;

  function automatic logic valid_addr(input logic [ADDR_W-1:0] a);
    return (a != '0) && ({1'b0, a} < CNT);
  endfunction

  assign wr_hit = wr_en && valid_addr(wr_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd1 = valid_addr(ra1) ? regs[ra1] : '0;
    rd2 = valid_addr(ra2) ? regs[ra2] : '0;
`ifdef ID_WB_BYPASS_EN
    if (wr_hit && (wr_addr == ra1)) rd1 = wr_data;
    if (wr_hit && (wr_addr == ra2)) rd2 = wr_data;
`endif
  end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS decode stage: register read, R/I decode, load-use stall, registered ID/EX output.
// Optional ID_WB_BYPASS_EN forwards same-cycle write-back into the operands captured.
module id_stage_pipe
  import mips_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int REG_CNT = DEF_REG_CNT,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input logic          CLK,
  input logic          RST,
  id_stage_pipe_if.slave bus
);
  logic [5:0]        opcode;
  logic [4:0]        rs_f, rt_f, rd_f;
  logic [15:0]       imm;
  logic [ADDR_W-1:0] rs_a, rt_a, rd_a;
  logic [DATA_W-1:0] rd1, rd2;

  logic              is_r_n;
  logic [ADDR_W-1:0] dst_n;
  logic [DATA_W-1:0] ext_n;
  logic              hazard;
  logic              accept;

  logic              vld_q;
  logic [DATA_W-1:0] rdata1_q, rdata2_q, ed32_q;
  logic [ADDR_W-1:0] dst_q;
  logic              is_r_q;

  assign opcode = bus.Ins[OP_MSB:OP_LSB];
  assign rs_f   = bus.Ins[RS_MSB:RS_LSB];
  assign rt_f   = bus.Ins[RT_MSB:RT_LSB];
  assign rd_f   = bus.Ins[RD_MSB:RD_LSB];
  assign imm    = bus.Ins[IMM_MSB:IMM_LSB];

  assign rs_a = ADDR_W'(rs_f);
  assign rt_a = ADDR_W'(rt_f);
  assign rd_a = ADDR_W'(rd_f);

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .REG_CNT(REG_CNT),
    .ADDR_W (ADDR_W)
  ) u_rf (
    .clk    (CLK),
    .rst    (RST),
    .wr_en  (bus.wb_en),
    .wr_addr(bus.wb_addr),
    .wr_data(bus.wb_data),
    .ra1    (rs_a),
    .ra2    (rt_a),
    .rd1    (rd1),
    .rd2    (rd2)
  );

  always_comb begin
    is_r_n = (opcode == R_FORM);
    dst_n  = is_r_n ? rd_a : rt_a;
    if (is_r_n)                  ext_n = '0;
    else if (op_zero_ext(opcode)) ext_n = DATA_W'(imm);
    else                         ext_n = DATA_W'($signed(imm));
  end

  // Stall on a load in EX whose result this instruction reads.
  assign hazard = bus.ex_load && (bus.ex_dst != '0) &&
                  ((bus.ex_dst == rs_a) || (op_uses_rt(opcode) && (bus.ex_dst == rt_a)));

  assign bus.in_ready = !RST && !hazard && (!vld_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q    <= 1'b0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      ed32_q   <= '0;
      dst_q    <= '0;
      is_r_q   <= 1'b0;
    end else if (accept) begin
      vld_q    <= 1'b1;
      rdata1_q <= rd1;
      rdata2_q <= rd2;
      ed32_q   <= ext_n;
      dst_q    <= dst_n;
      is_r_q   <= is_r_n;
    end else if (bus.out_ready) begin
      vld_q    <= 1'b0;
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.Rdata1    = rdata1_q;
  assign bus.Rdata2    = rdata2_q;
  assign bus.Ed32      = ed32_q;
  assign bus.dst       = dst_q;
  assign bus.is_rform  = is_r_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed, table-driven bench for id_stage_pipe; expectations adapt to ID_WB_BYPASS_EN.
module tb_id_stage_pipe;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 CLK = ~CLK;

  id_stage_pipe_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  id_stage_pipe #(.DATA_W(32), .REG_CNT(32), .ADDR_W(5)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] ed;
    logic [4:0]  dst;
    logic        rform;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d;
    step();
    bus.wb_en = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] ed, input logic [4:0] d, input logic rf);
    chk({name, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, ".Rdata1"},    bus.Rdata1, r1);
    chk({name, ".Rdata2"},    bus.Rdata2, r2);
    chk({name, ".Ed32"},      bus.Ed32, ed);
    chk({name, ".dst"},       32'(bus.dst), 32'(d));
    chk({name, ".is_rform"},  32'(bus.is_rform), 32'(rf));
  endtask

  localparam logic [31:0] ADD_6_1_2  = 32'h00223020;
  localparam logic [31:0] ADDI_4_3_M2 = 32'h2064FFFE;

  initial begin
    logic [31:0] exp_byp;

    //               name     ins           Rdata1        Rdata2        Ed32          dst   rform
    vecs[0] = '{"addi",  ADDI_4_3_M2,   32'h00000010, 32'h0,        32'hFFFFFFFE, 5'd4, 1'b0};
    vecs[1] = '{"ori",   32'h34648000,  32'h00000010, 32'h0,        32'h00008000, 5'd4, 1'b0};
    vecs[2] = '{"add",   ADD_6_1_2,     32'd7,        32'd9,        32'h0,        5'd6, 1'b1};
    vecs[3] = '{"andi",  32'h30A7FFFF,  32'h00001234, 32'h0,        32'h0000FFFF, 5'd7, 1'b0};
    vecs[4] = '{"lw",    32'h8C480004,  32'd9,        32'h0,        32'h00000004, 5'd8, 1'b0};
    vecs[5] = '{"beq",   32'h1022FFFF,  32'd7,        32'd9,        32'hFFFFFFFF, 5'd2, 1'b0};
    vecs[6] = '{"xori0", 32'h38090001,  32'h0,        32'h0,        32'h00000001, 5'd9, 1'b0};

    bus.in_valid = 0; bus.Ins = '0; bus.wb_en = 0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.ex_load = 0; bus.ex_dst = '0; bus.out_ready = 1;

    step(); step();
    chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    RST = 1'b0;

    wb_write(5'd1, 32'd7);
    wb_write(5'd2, 32'd9);
    wb_write(5'd3, 32'h10);
    wb_write(5'd5, 32'h1234);
    wb_write(5'd0, 32'hDEAD);

    // Back-to-back stream: one accept per cycle with out_ready held high.
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1; bus.Ins = vecs[i].ins;
      #1;
      chk({vecs[i].name, ".in_ready"}, 32'(bus.in_ready), 32'd1);
      step();
      chk_out(vecs[i].name, vecs[i].r1, vecs[i].r2, vecs[i].ed, vecs[i].dst, vecs[i].rform);
    end
    bus.in_valid = 1'b0;
    step();
    chk("drain.out_valid", 32'(bus.out_valid), 32'd0);

    // Load-use stall: load to r2 in EX blocks add r6,r1,r2 for one bubble.
    bus.ex_load = 1'b1; bus.ex_dst = 5'd2;
    bus.Ins = 32'h20620000;  // addi r2,r3,0 does not read r2
    #1;
    chk("haz.addi_rt_dst.in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.Ins = ADD_6_1_2;
    #1;
    chk("haz.in_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk("haz.bubble", 32'(bus.out_valid), 32'd0);
    bus.ex_load = 1'b0;
    #1;
    chk("haz.release.in_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk_out("haz.accept", 32'd7, 32'd9, 32'h0, 5'd6, 1'b1);

    // Backpressure: entry frozen for 3 cycles, then drains as the next is taken.
    bus.out_ready = 1'b0; bus.Ins = ADDI_4_3_M2;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
      step();
      chk_out("bp.hold", 32'd7, 32'd9, 32'h0, 5'd6, 1'b1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp.release.in_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk_out("bp.next", 32'h10, 32'h0, 32'hFFFFFFFE, 5'd4, 1'b0);

    // Same-cycle write-back of r1 while add reads r1.
`ifdef ID_WB_BYPASS_EN
    exp_byp = 32'h55;
`else
    exp_byp = 32'd7;
`endif
    bus.Ins = ADD_6_1_2;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 32'h55;
    step();
    bus.wb_en = 1'b0;
    chk("byp.same_cycle.Rdata1", bus.Rdata1, exp_byp);
    step();
    chk("byp.next_cycle.Rdata1", bus.Rdata1, 32'h55);

    // Reset with a valid entry held.
    chk("rst2.pre_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0;
    RST = 1'b1;
    #1;
    chk("rst2.in_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk("rst2.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst2.Rdata1", bus.Rdata1, 32'h0);
    chk("rst2.Rdata2", bus.Rdata2, 32'h0);
    chk("rst2.Ed32", bus.Ed32, 32'h0);
    chk("rst2.dst", 32'(bus.dst), 32'h0);
    chk("rst2.is_rform", 32'(bus.is_rform), 32'h0);
    RST = 1'b0;
    bus.in_valid = 1'b1; bus.Ins = 32'h30A7FFFF;  // andi r7,r5 reads r5
    step();
    bus.in_valid = 1'b0;
    chk_out("rst2.r5", 32'h0, 32'h0, 32'h0000FFFF, 5'd7, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised, pipelined instruction-decode stage for the MIPS datapath.
- Holds the general-purpose register file and decodes R/I formats into operands, immediate and destination.
- Takes a dedicated write-back port, detects load-use hazards and registers its outputs into an ID/EX stage register with a valid/ready handshake.
- Sits between IF and EX.

Parameters:
- DATA_W, 32, register and operand width (bits); must be ≥ 16.
- REG_CNT, 32, number of architectural registers; register 0 is hardwired zero.
- ADDR_W, 5, register address width; REG_CNT ≤ 2**ADDR_W.

Ports:
- CLK  in  1  clock, rising-edge.
- RST  in  1  synchronous active-high reset.
- in_valid  in  1  IF presents a valid instruction.
- in_ready  out  1  ID accepts the instruction this cycle.
- Ins  in  32  instruction word.
- wb_en  in  1  write-back enable.
- wb_addr  in  ADDR_W  write-back register.
- wb_data  in  DATA_W  write-back value.
- ex_load  in  1  EX currently holds a valid load.
- ex_dst  in  ADDR_W  destination of the load in EX.
- out_valid  out  1  ID/EX register holds a valid entry.
- out_ready  in  1  EX accepts the entry.
- Rdata1  out  DATA_W  rs operand (registered).
- Rdata2  out  DATA_W  rt operand (registered).
- Ed32  out  DATA_W  extended immediate (registered).
- dst  out  ADDR_W  destination register (registered).
- is_rform  out  1  entry is R format (registered).

Behaviour:
- Clock and reset: one clock, CLK; RST is synchronous, active-high.
- Reset response: on a CLK edge with RST=1, all registers become 0; out_valid, Rdata1, Rdata2, Ed32, dst and is_rform become 0.
- in_ready is 0 while RST=1.
- Reset mid-transfer: any entry in the stage register is discarded with no handshake.
- Register file writes:
  - On the clock edge, the register at wb_addr is written when wb_en=1, wb_addr≠0 and wb_addr<REG_CNT.
  - Writes to register 0 or to an out-of-range address are ignored.
  - Reads of register 0 or an out-of-range address return 0.
- Decode:
  - opcode = Ins[31:26], rs = Ins[25:21], rt = Ins[20:16], rd = Ins[15:11].
  - Opcode 0 (R_FORM): dst = rd, Ed32 = 0, is_rform = 1.
  - Any other opcode: dst = rt, is_rform = 0.
  - Ed32 is the zero-extended Ins[15:0] for opcodes 0x0C/0x0D/0x0E (andi/ori/xori); otherwise it is Ins[15:0] sign-extended to DATA_W.
  - Address fields are truncated or zero-padded to ADDR_W.
- Hazard:
  - uses_rt is 1 for R_FORM, 0x2B (sw), 0x04 (beq) and 0x05 (bne).
  - hazard = ex_load & (ex_dst≠0) & ((ex_dst==rs) | (uses_rt & ex_dst==rt)).
- Handshake:
  - in_ready = !RST & !hazard & (!out_valid | out_ready).
  - Accept (in_valid & in_ready): load the stage register with the decoded fields and set out_valid=1. Latency: 1 cycle.
  - out_ready=1 with no accept: out_valid → 0. When a hazard causes this, it is the inserted bubble.
  - out_valid=1 and out_ready=0: all outputs hold stable. Ins is ignored while in_ready=0.
- Throughput: one instruction per cycle with no hazard and out_ready held at 1.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined: write-first bypass. If wb_en, wb_addr≠0 and wb_addr equals rs (or rt), the value captured that cycle is wb_data instead of the stale register.
- Undefined: reads see only the pre-edge register contents; same-cycle write-back is visible one cycle later. The bench checks both builds.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants R_FORM, OP_SW, OP_BEQ, OP_BNE, OP_ANDI, OP_ORI, OP_XORI;
  - field-slice positions;
  - default DATA_W/REG_CNT/ADDR_W.
- One sub-module: regfile_2r1w. It contains the register storage, synchronous reset, r0-zero logic and the optional bypass. It is parametrised by DATA_W/REG_CNT/ADDR_W.
- Decode, hazard detection and the stage register stay in id_stage_pipe.

Test Plan:
- Reset: assert RST during a valid entry → next cycle out_valid=0, all outputs 0, and reading r5 returns 0.
- I-format sign extension: write r3=0x00000010, then send addi r4,r3,-2 (0x2064FFFE) → Rdata1=0x10, Ed32=0xFFFFFFFE, dst=4, is_rform=0.
- I-format zero extension: send ori r4,r3,0x8000 → Ed32=0x00008000.
- R-format: r1=7, r2=9, add r6,r1,r2 (0x00223020) → Rdata1=7, Rdata2=9, Ed32=0, dst=6, is_rform=1.
- Load-use: ex_load=1, ex_dst=2, then add r6,r1,r2 → in_ready=0 and one bubble (out_valid=0). Drop ex_load → accepted next cycle.
- Backpressure: out_ready=0 for 3 cycles with a valid entry → outputs frozen, in_ready=0. Release → entry drains and the next instruction is accepted in the same cycle.
- r0 and bypass: wb_en with wb_addr=0, wb_data=0xDEAD → r0 still reads 0. With ID_WB_BYPASS_EN, wb r1=0x55 in the same cycle as reading r1 → Rdata1=0x55; without the macro → old value.
